// File: rtl/div_frec_multi.sv
// ---------------------------------------------------------------------------
// div_frec_multi
// Multi-channel, runtime-programmable clock-enable generator. Each channel
// runs its own divide counter and produces a one-cycle tick and a 50%-duty
// square wave. A new divisor is either parked in a shadow register and
// picked up at the terminal count, or applied immediately with a restart.
//
// Optional feature: define DIV_FREC_SYNC_EN to add the sync_i port, which
// restarts every channel in phase and applies any pending divisor.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   en_i     in   [N_CH]  per-channel count enable
//   cfg_we   in   divisor write strobe (single cycle)
//   cfg_ch   in   [4]     target channel; values >= N_CH are ignored
//   cfg_div  in   [CNT_W] divisor value
//   cfg_now  in   1 = apply immediately, 0 = apply at next terminal count
//   sync_i   in   (DIV_FREC_SYNC_EN only) phase-aligned restart of all channels
//   tick_o   out  [N_CH]  one-cycle pulse every div+1 enabled cycles
//   sq_o     out  [N_CH]  square wave, toggles at every terminal count
//   pend_o   out  [N_CH]  channel holds a divisor not yet applied
// ---------------------------------------------------------------------------

// One divider channel. The write request is already decoded for this channel.
module div_frec_ch #(
   parameter int unsigned CNT_W       = 25,
   parameter int unsigned DIV_DEFAULT = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en_i,
   input  logic             sync_i,
   input  logic             wr_i,
   input  logic             wr_now_i,
   input  logic [CNT_W-1:0] wr_div_i,
   output logic             tick_o,
   output logic             sq_o,
   output logic             pend_o
);

   logic [CNT_W-1:0] cnt_q,    cnt_d;
   logic [CNT_W-1:0] div_q,    div_d;
   logic [CNT_W-1:0] shadow_q, shadow_d;
   logic             pend_q,   pend_d;
   logic             tick_q,   tick_d;
   logic             sq_q,     sq_d;
   logic             tc;

   always_comb begin
      cnt_d    = cnt_q;
      div_d    = div_q;
      shadow_d = shadow_q;
      pend_d   = pend_q;
      tick_d   = 1'b0;
      sq_d     = sq_q;
      tc       = 1'b0;

      if (sync_i) begin
         cnt_d = '0;
         sq_d  = 1'b0;
         if (pend_q) begin
            div_d  = shadow_q;
            pend_d = 1'b0;
         end
      end else if (en_i) begin
         if (cnt_q == div_q) begin
            tc     = 1'b1;
            cnt_d  = '0;
            tick_d = 1'b1;
            sq_d   = ~sq_q;
            if (pend_q) begin
               div_d  = shadow_q;
               pend_d = 1'b0;
            end
         end else begin
            // cnt never exceeds div, so this cannot overflow past div
            cnt_d = cnt_q + CNT_W'(1);
         end
      end

      // The write is evaluated last so it wins over sync and terminal count.
      if (wr_i) begin
         if (wr_now_i) begin
            div_d  = wr_div_i;
            cnt_d  = '0;
            sq_d   = 1'b0;
            tick_d = 1'b0;
            pend_d = 1'b0;
         end else if (tc) begin
            // Landing exactly on the terminal count: skip the shadow so the
            // new period starts right now rather than one period later.
            div_d  = wr_div_i;
            pend_d = 1'b0;
         end else begin
            shadow_d = wr_div_i;
            pend_d   = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q    <= '0;
         div_q    <= CNT_W'(DIV_DEFAULT);
         shadow_q <= '0;
         pend_q   <= 1'b0;
         tick_q   <= 1'b0;
         sq_q     <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         div_q    <= div_d;
         shadow_q <= shadow_d;
         pend_q   <= pend_d;
         tick_q   <= tick_d;
         sq_q     <= sq_d;
      end
   end

   assign tick_o = tick_q;
   assign sq_o   = sq_q;
   assign pend_o = pend_q;

endmodule

module div_frec_multi #(
   parameter int unsigned N_CH        = 2,
   parameter int unsigned CNT_W       = 25,
   parameter int unsigned DIV_DEFAULT = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_CH-1:0]  en_i,
   input  logic             cfg_we,
   input  logic [3:0]       cfg_ch,
   input  logic [CNT_W-1:0] cfg_div,
   input  logic             cfg_now,
`ifdef DIV_FREC_SYNC_EN
   input  logic             sync_i,
`endif
   output logic [N_CH-1:0]  tick_o,
   output logic [N_CH-1:0]  sq_o,
   output logic [N_CH-1:0]  pend_o
);

   logic sync_w;

`ifdef DIV_FREC_SYNC_EN
   assign sync_w = sync_i;
`else
   assign sync_w = 1'b0;
`endif

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      logic wr_sel;

      // Channel numbers >= N_CH match no instance, so such writes vanish.
      assign wr_sel = cfg_we && (cfg_ch == 4'(g));

      div_frec_ch #(
         .CNT_W       (CNT_W),
         .DIV_DEFAULT (DIV_DEFAULT)
      ) u_ch (
         .clk      (clk),
         .rst_n    (rst_n),
         .en_i     (en_i[g]),
         .sync_i   (sync_w),
         .wr_i     (wr_sel),
         .wr_now_i (cfg_now),
         .wr_div_i (cfg_div),
         .tick_o   (tick_o[g]),
         .sq_o     (sq_o[g]),
         .pend_o   (pend_o[g])
      );
   end

endmodule

// File: tb/tb_div_frec_multi.sv
module tb_div_frec_multi;

   localparam int N_CH        = 2;
   localparam int CNT_W       = 4;
   localparam int DIV_DEFAULT = 1;

   typedef struct packed {
      logic [N_CH-1:0] tick;
      logic [N_CH-1:0] sq;
      logic [N_CH-1:0] pend;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [N_CH-1:0]  en_i;
   logic             cfg_we;
   logic [3:0]       cfg_ch;
   logic [CNT_W-1:0] cfg_div;
   logic             cfg_now;
   logic             sync_i;
   logic [N_CH-1:0]  tick_o;
   logic [N_CH-1:0]  sq_o;
   logic [N_CH-1:0]  pend_o;

   int n_pass = 0;
   int n_chk  = 0;
   exp_t exp_q[$];

   // reference model: each channel has a period of (div+1) enabled cycles and
   // "elapsed" counts how many of them have gone by
   int m_div[N_CH];
   int m_elapsed[N_CH];
   int m_shadow[N_CH];
   bit m_sq[N_CH];
   bit m_tick[N_CH];
   bit m_pend[N_CH];

   always #5 clk = ~clk;

   div_frec_multi #(
      .N_CH        (N_CH),
      .CNT_W       (CNT_W),
      .DIV_DEFAULT (DIV_DEFAULT)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .en_i    (en_i),
      .cfg_we  (cfg_we),
      .cfg_ch  (cfg_ch),
      .cfg_div (cfg_div),
      .cfg_now (cfg_now),
`ifdef DIV_FREC_SYNC_EN
      .sync_i  (sync_i),
`endif
      .tick_o  (tick_o),
      .sq_o    (sq_o),
      .pend_o  (pend_o)
   );

   task automatic check(input string name, input logic [N_CH-1:0] act, input logic [N_CH-1:0] req);
      n_chk++;
      if (act === req) n_pass++;
      else $display("FAIL %s actual=%b required=%b at %0t", name, act, req, $time);
   endtask

   function automatic void model_reset();
      for (int c = 0; c < N_CH; c++) begin
         m_div[c] = DIV_DEFAULT; m_elapsed[c] = 0; m_shadow[c] = 0;
         m_sq[c] = 0; m_tick[c] = 0; m_pend[c] = 0;
      end
   endfunction

   function automatic void model_edge(input logic [N_CH-1:0] en, input logic we, input int ch,
                                      input int dv, input logic now, input logic sy);
      for (int c = 0; c < N_CH; c++) begin
         bit period_done = 0;
         m_tick[c] = 0;
         if (sy) begin
            m_elapsed[c] = 0; m_sq[c] = 0;
            if (m_pend[c]) begin m_div[c] = m_shadow[c]; m_pend[c] = 0; end
         end else if (en[c]) begin
            m_elapsed[c]++;
            if (m_elapsed[c] == m_div[c] + 1) begin
               period_done = 1;
               m_elapsed[c] = 0; m_tick[c] = 1; m_sq[c] = !m_sq[c];
               if (m_pend[c]) begin m_div[c] = m_shadow[c]; m_pend[c] = 0; end
            end
         end
         if (we && ch == c) begin
            if (now) begin
               m_div[c] = dv; m_elapsed[c] = 0; m_sq[c] = 0; m_tick[c] = 0; m_pend[c] = 0;
            end else if (period_done) begin
               m_div[c] = dv; m_pend[c] = 0;
            end else begin
               m_shadow[c] = dv; m_pend[c] = 1;
            end
         end
      end
   endfunction

   function automatic exp_t model_out();
      exp_t e;
      for (int c = 0; c < N_CH; c++) begin
         e.tick[c] = m_tick[c]; e.sq[c] = m_sq[c]; e.pend[c] = m_pend[c];
      end
      return e;
   endfunction

   // called 2 time units after a rising edge; drives inputs for the next edge
   task automatic step(input logic [N_CH-1:0] en, input logic we, input logic [3:0] ch,
                       input logic [CNT_W-1:0] dv, input logic now, input logic sy, input logic rst);
      logic sy_eff;
`ifdef DIV_FREC_SYNC_EN
      sy_eff = sy;
`else
      sy_eff = 1'b0;
`endif
      en_i = en; cfg_we = we; cfg_ch = ch; cfg_div = dv; cfg_now = now; sync_i = sy_eff;
      if (rst) begin
         rst_n = 1'b0;
         model_reset();
         #1;
         check("async_reset_tick", tick_o, '0);
         check("async_reset_sq", sq_o, '0);
         check("async_reset_pend", pend_o, '0);
      end else begin
         rst_n = 1'b1;
         model_edge(en, we, int'(ch), int'(dv), now, sy_eff);
      end
      exp_q.push_back(model_out());
      @(posedge clk);
      #2;
   endtask

   task automatic idle(input int n, input logic [N_CH-1:0] en);
      for (int k = 0; k < n; k++) step(en, 1'b0, 4'd0, '0, 1'b0, 1'b0, 1'b0);
   endtask

   // monitor: every edge the DUT presents a new output word
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("tick_o", tick_o, e.tick);
            check("sq_o", sq_o, e.sq);
            check("pend_o", pend_o, e.pend);
         end
      end
   end

   initial begin
      int guard;
      rst_n = 1'b0; en_i = '0; cfg_we = 1'b0; cfg_ch = '0; cfg_div = '0;
      cfg_now = 1'b0; sync_i = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #2;
      check("reset_tick", tick_o, '0);
      check("reset_sq", sq_o, '0);
      check("reset_pend", pend_o, '0);

      // default divisor, both enabled
      idle(8, 2'b11);
      // ch1 pending write mid-period
      step(2'b11, 1'b1, 4'd1, 4'd4, 1'b0, 1'b0, 1'b0);
      idle(14, 2'b11);
      // ch0 immediate write
      step(2'b11, 1'b1, 4'd0, 4'd9, 1'b1, 1'b0, 1'b0);
      idle(23, 2'b11);
      // ch0 write landing exactly on its terminal count
      guard = 0;
      while (m_elapsed[0] != m_div[0] && guard < 40) begin
         idle(1, 2'b11);
         guard++;
      end
      step(2'b11, 1'b1, 4'd0, 4'd3, 1'b0, 1'b0, 1'b0);
      idle(10, 2'b11);
      // freeze ch1 for 7 cycles
      idle(2, 2'b11);
      idle(7, 2'b01);
      idle(10, 2'b11);
      // out-of-range channel
      step(2'b11, 1'b1, 4'd5, 4'd0, 1'b1, 1'b0, 1'b0);
      step(2'b11, 1'b1, 4'd5, 4'd7, 1'b0, 1'b0, 1'b0);
      idle(6, 2'b11);
      // largest divisor wraps through all-ones
      step(2'b11, 1'b1, 4'd1, 4'd15, 1'b1, 1'b0, 1'b0);
      idle(34, 2'b11);
`ifdef DIV_FREC_SYNC_EN
      step(2'b11, 1'b1, 4'd0, 4'd2, 1'b1, 1'b0, 1'b0);
      step(2'b11, 1'b1, 4'd1, 4'd5, 1'b1, 1'b0, 1'b0);
      idle(4, 2'b11);
      step(2'b11, 1'b0, 4'd0, '0, 1'b0, 1'b1, 1'b0);
      idle(8, 2'b11);
`endif
      // mid-run reset with a pending write
      step(2'b11, 1'b1, 4'd0, 4'd6, 1'b0, 1'b0, 1'b0);
      step(2'b11, 1'b0, 4'd0, '0, 1'b0, 1'b0, 1'b1);
      idle(6, 2'b11);

      for (int k = 0; k < 3000; k++) begin
         logic [N_CH-1:0] en;
         logic [CNT_W-1:0] dv;
         for (int c = 0; c < N_CH; c++) en[c] = ($urandom_range(0, 9) != 0);
         dv = ($urandom_range(0, 7) == 0) ? CNT_W'(15) : CNT_W'($urandom_range(0, 6));
         step(en, ($urandom_range(0, 5) == 0), 4'($urandom_range(0, 4)), dv,
              ($urandom_range(0, 2) == 0), ($urandom_range(0, 39) == 0),
              ($urandom_range(0, 299) == 0));
      end

      guard = 0;
      while (exp_q.size() > 0 && guard < 5) begin
         @(posedge clk);
         #2;
         guard++;
      end
      n_chk++;
      if (exp_q.size() == 0) n_pass++;
      else $display("FAIL drain actual=%0d required=0 entries left", exp_q.size());

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
